// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - fully-connected layer engine: LANES-wide MAC over CHUNKS chunks per neuron, bias, saturate.
// Optional macro FC_LAYER_RELU_EN clamps negative results to zero after saturation.
module fc_layer_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_DIM     = 120,
  parameter int OUT_DIM    = 84,
  parameter int LANES      = 4,
  localparam int CHUNKS    = IN_DIM / LANES,
  localparam int IN_AW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
  localparam int W_AW      = (OUT_DIM * CHUNKS > 1) ? $clog2(OUT_DIM * CHUNKS) : 1,
  localparam int O_AW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [IN_AW-1:0]            in_addr,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [W_AW-1:0]             w_addr,
  input  logic [LANES*DATA_WIDTH-1:0] w_data,
  output logic [O_AW-1:0]             bias_addr,
  input  logic [DATA_WIDTH-1:0]       bias_data,
  output logic                        out_wr_en,
  output logic [O_AW-1:0]             out_addr,
  output logic [DATA_WIDTH-1:0]       out_data
);

  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(IN_DIM) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

  state_t                  state;
  logic                    rst_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic [DATA_WIDTH-1:0]   result;

  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum = lane_sum
               + ACC_W'($signed(in_data[j*DATA_WIDTH +: DATA_WIDTH]))
               * ACC_W'($signed(w_data[j*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // acc_sum includes the chunk returning this cycle, so DRAIN can form the final result directly.
  assign acc_sum = acc + lane_sum;
  assign biased  = acc_sum + (ACC_W'($signed(bias_data)) <<< FRAC_BITS);
  assign shifted = biased >>> FRAC_BITS;

  always_comb begin
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
`ifdef FC_LAYER_RELU_EN
    if (result[DATA_WIDTH-1]) begin
      result = '0;
    end
`endif
  end

  // rst_q blocks start on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rst_q     <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      bias_addr <= '0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      rst_q     <= 1'b1;
      done      <= 1'b0;
      out_wr_en <= 1'b0;
      out_data  <= '0;
      case (state)
        IDLE: begin
          if (start && rst_q) begin
            state     <= MAC;
            busy      <= 1'b1;
            acc       <= '0;
            in_addr   <= '0;
            w_addr    <= '0;
            bias_addr <= '0;
          end
        end
        MAC: begin
          if (in_addr != '0) begin
            acc <= acc_sum;
          end
          if (in_addr != IN_AW'(CHUNKS - 1)) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          acc       <= acc_sum;
          state     <= WRITE;
          out_wr_en <= 1'b1;
          out_addr  <= bias_addr;
          out_data  <= result;
        end
        WRITE: begin
          acc <= '0;
          if (bias_addr != O_AW'(OUT_DIM - 1)) begin
            state     <= MAC;
            bias_addr <= bias_addr + 1'b1;
            in_addr   <= '0;
            w_addr    <= w_addr + 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - directed self-checking bench for fc_layer_engine (IN_DIM=8, OUT_DIM=4, LANES=4).
module tb_fc_layer_engine;

  localparam int DW = 16;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [0:0]    in_addr;
  logic [63:0]   in_data;
  logic [2:0]    w_addr;
  logic [63:0]   w_data;
  logic [1:0]    bias_addr;
  logic [15:0]   bias_data;
  logic          out_wr_en;
  logic [1:0]    out_addr;
  logic [15:0]   out_data;

  logic [63:0]   in_mem [2];
  logic [63:0]   w_mem  [8];
  logic [15:0]   b_mem  [4];
  logic [15:0]   e      [4];

  int checks = 0;
  int errors = 0;

  fc_layer_engine #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .IN_DIM(8), .OUT_DIM(4), .LANES(LN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data   <= in_mem[in_addr];
    w_data    <= w_mem[w_addr];
    bias_data <= b_mem[bias_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < 2; i++) in_mem[i] = {LN{iv}};
    for (int i = 0; i < 8; i++) w_mem[i] = {LN{wv}};
    for (int i = 0; i < 4; i++) b_mem[i] = bv;
  endtask

  // Start lands on edge 0; sample c is taken at the falling edge after edge c-1.
  task automatic run_pass(input string tag, input logic [15:0] exp [4], input int restart_cyc);
    int writes;
    int dones;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    writes = 0;
    dones  = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == restart_cyc);
      if (out_wr_en) begin
        if (writes < 4) begin
          chk({tag, "_addr"}, 32'(out_addr), 32'(writes));
          chk({tag, "_data"}, 32'(out_data), 32'(exp[writes]));
          chk({tag, "_wcyc"}, 32'(c), 32'(4 * (writes + 1)));
        end
        writes++;
      end else begin
        chk({tag, "_zero"}, 32'(out_data), 32'd0);
      end
      if (done) begin
        chk({tag, "_done_cyc"}, 32'(c), 32'd17);
        dones++;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(c <= 17));
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_nwrites"}, 32'(writes), 32'd4);
    chk({tag, "_ndone"}, 32'(dones), 32'd1);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    fill(16'h0100, 16'h0080, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr", 32'(out_wr_en), 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    e = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    run_pass("basic", e, 0);

    fill(16'h7FFF, 16'h7FFF, 16'h0000);
    e = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_pass("satpos", e, 0);

    fill(16'h7FFF, 16'h8001, 16'h0000);
`ifdef FC_LAYER_RELU_EN
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
    e = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`endif
    run_pass("satneg", e, 0);

    fill(16'h0100, 16'hFFC0, 16'h0100);
`ifdef FC_LAYER_RELU_EN
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
    e = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
`endif
    run_pass("negbias", e, 0);

    // Neuron o: 4*1.0*0.25(o+1) + 4*2.0*0.0625(o+1) - 1.0 = 1.5(o+1) - 1.0
    in_mem[0] = {LN{16'h0100}};
    in_mem[1] = {LN{16'h0200}};
    for (int o = 0; o < 4; o++) begin
      w_mem[2*o]   = {LN{16'(16'h0040 * (o + 1))}};
      w_mem[2*o+1] = {LN{16'(16'h0010 * (o + 1))}};
      b_mem[o]     = 16'hFF00;
    end
    e = '{16'h0080, 16'h0200, 16'h0380, 16'h0500};
    run_pass("mixed", e, 0);

    fill(16'h0100, 16'h0080, 16'h0000);
    e = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    run_pass("restart", e, 5);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_wr", 32'(out_wr_en), 32'd0);
    chk("arst_inaddr", 32'(in_addr), 32'd0);
    chk("arst_waddr", 32'(w_addr), 32'd0);
    chk("arst_baddr", 32'(bias_addr), 32'd0);
    chk("arst_oaddr", 32'(out_addr), 32'd0);
    chk("arst_odata", 32'(out_data), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_hold_wr", 32'(out_wr_en), 32'd0);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("release_start_ignored", 32'(busy), 32'd0);

    e = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    run_pass("after_rst", e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the signed fixed-point word width.
REQ-002 The block SHALL have parameter FRAC_BITS, default 8, the fraction bits of every operand and result.
REQ-003 The block SHALL have parameter IN_DIM, default 120, the input vector length; IN_DIM % LANES == 0 is required.
REQ-004 The block SHALL have parameter OUT_DIM, default 84, the number of output neurons.
REQ-005 The block SHALL have parameter LANES, default 4, the number of parallel multipliers; CHUNKS = IN_DIM/LANES.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit, a one-cycle request to begin one layer pass.
REQ-009 The block SHALL have port busy, output, 1 bit, high from the cycle after start is accepted until done.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have port in_addr, output, clog2(CHUNKS) bits, the input memory chunk address.
REQ-012 The block SHALL have port in_data, input, LANES*DATA_WIDTH bits, with lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The block SHALL have port w_addr, output, clog2(OUT_DIM*CHUNKS) bits, the weight address, equal to o*CHUNKS+k.
REQ-014 The block SHALL have port w_data, input, LANES*DATA_WIDTH bits, the weight lanes, packed the same way as in_data.
REQ-015 The block SHALL have port bias_addr, output, clog2(OUT_DIM) bits, the bias address, equal to o.
REQ-016 The block SHALL have port bias_data, input, DATA_WIDTH bits, the signed bias.
REQ-017 The block SHALL have ports out_wr_en (input/output: output, 1 bit), out_addr (output, clog2(OUT_DIM) bits) and out_data (output, DATA_WIDTH bits), forming the result write port.

Function
REQ-018 All three memories SHALL be synchronous-read, with data valid exactly one cycle after the address is presented.
REQ-019 The FSM SHALL have the states IDLE, MAC, DRAIN, WRITE and DONE; start is sampled only in IDLE, and start in any other state is ignored.
REQ-020 IDLE + start -> MAC, with o=0 and k=0.
REQ-021 MAC SHALL run for CHUNKS cycles, presenting in_addr=k and w_addr=o*CHUNKS+k with k incrementing each cycle; bias_addr=o is held throughout.
REQ-022 Each cycle in which data returns, the accumulator SHALL add the sum of LANES signed DATA_WIDTH x DATA_WIDTH products.
REQ-023 The accumulator width SHALL be ACC_W = 2*DATA_WIDTH + clog2(IN_DIM) + 1, and it SHALL never overflow.
REQ-024 MAC SHALL go to DRAIN for one cycle, in which the last chunk is accumulated.
REQ-025 DRAIN SHALL go to WRITE for one cycle, in which result = (acc + (bias_data <<< FRAC_BITS)) >>> FRAC_BITS, arithmetic and truncating.
REQ-026 The result SHALL be saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 In WRITE, out_wr_en=1, out_addr=o and out_data=result for exactly one cycle, and the accumulator is cleared.
REQ-028 WRITE SHALL go to MAC with o+1 if o<OUT_DIM-1, else to DONE.
REQ-029 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 Latency SHALL be as follows: with start accepted on edge 0, done is high in cycle OUT_DIM*(CHUNKS+2)+1, and exactly OUT_DIM writes occur, in ascending out_addr order.
REQ-031 busy SHALL be 0 in IDLE and 1 in MAC, DRAIN, WRITE and DONE.
REQ-032 Addresses outside MAC SHALL be held at their last value; out_data SHALL be 0 whenever out_wr_en=0.

Reset
REQ-033 rst low SHALL immediately force IDLE, and all counters and the accumulator to 0, with busy=0, done=0 and out_wr_en=0, and all addresses and out_data at 0.
REQ-034 Reset mid-pass SHALL abort the pass with no further writes; the next start SHALL begin from o=0.
REQ-035 Release of rst SHALL take effect on the next rising clk edge, with no start accepted in the release cycle.

Configuration
REQ-036 With macro FC_LAYER_RELU_EN defined, negative results SHALL be written as 0 after saturation; without it, signed results SHALL be written unchanged.
REQ-037 The macro SHALL affect neither latency nor any other port behaviour.

Verification (DATA_WIDTH=16, FRAC_BITS=8, IN_DIM=8, OUT_DIM=4, LANES=4)
REQ-038 All inputs 0x0100 (1.0), weights 0x0080 (0.5) and bias 0 -> 4 writes of 0x0400 to addresses 0..3, with done in cycle 17.
REQ-039 Inputs 0x7FFF and weights 0x7FFF -> every out_data=0x7FFF (saturated); negated weights -> 0x8000 without the macro, or 0x0000 with FC_LAYER_RELU_EN.
REQ-040 Inputs 1.0, weights -0.25 and bias 0x0100 -> out_data 0xFF00 without the macro, or 0x0000 with it.
REQ-041 start pulsed again in cycle 5 -> ignored: still exactly 4 writes and a single done pulse.
REQ-042 rst low in cycle 6 -> outputs cleared asynchronously and no writes; a restart then produces the full correct 4-write sequence.
